lights_checker: RTL and testbench

Consumer-side companion to the dynamic LED `lights` block. Samples the `colour` bus and `button` strobe every cycle, tracks the legal colour sequence 001→010→…→110→001, and flags any illegal step. Counts completed loops and mismatches, and drives three PWM-dimmed LED outputs from the tracked colour. It sits directly on the `lights` outputs in the top level and is also used by benches as a self-checking monitor.

---
 rtl/lights_checker.sv | 171 +++++++++++++++++
 tb/tb_lights_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lights_checker.sv
// lights_checker: monitors the colour/button outputs of a `lights` producer,
// tracks the legal colour cycle 001..110, flags illegal steps, counts loops
// and mismatches, and drives PWM-dimmed LEDs from the tracked colour.
module lights_checker #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned PWM_PERIOD = 8,
   parameter int unsigned DUTY       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       colour,
   input  logic             button,
   input  logic             clear,
   output logic             locked,
   output logic             err,
   output logic             err_pulse,
   output logic [CNT_W-1:0] loop_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic             led_r,
   output logic             led_g,
   output logic             led_b
);

   localparam int unsigned        PWM_W    = $clog2(PWM_PERIOD);
   localparam logic [PWM_W-1:0]   PWM_LAST = PWM_W'(PWM_PERIOD - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [2:0]         COL_FIRST = 3'b001;
   localparam logic [2:0]         COL_LAST  = 3'b110;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // Successor in the producer's colour cycle; out-of-range values restart at 001.
   function automatic logic [2:0] next_colour(input logic [2:0] c);
      if (c == 3'b000 || c == 3'b110 || c == 3'b111) begin
         return COL_FIRST;
      end
      return c + 3'd1;
   endfunction

   function automatic logic is_legal(input logic [2:0] c);
      return (c >= COL_FIRST) && (c <= COL_LAST);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   state_t           state_q,          state_d;
   logic [2:0]       cur_colour_q,     cur_colour_d;
   logic             prev_button_q,    prev_button_d;
   logic [PWM_W-1:0] pwm_cnt_q,        pwm_cnt_d;
   logic             locked_q,         locked_d;
   logic             err_q,            err_d;
   logic             err_pulse_q,      err_pulse_d;
   logic [CNT_W-1:0] loop_count_q,     loop_count_d;
   logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;

   logic [2:0] expected_colour;
   logic       mismatch;
   logic       wrap;
   logic       pwm_on;

   // Next-state logic: FSM transitions, captures, counters and PWM counter.
   always_comb begin
      // NOTE: every _d starts from its _q value so no branch below can leave it
      // unassigned; an incomplete assignment here would infer a latch.
      state_d          = state_q;
      cur_colour_d     = cur_colour_q;
      prev_button_d    = prev_button_q;
      err_d            = err_q;
      loop_count_d     = loop_count_q;
      mismatch_count_d = mismatch_count_q;
      mismatch         = 1'b0;
      wrap             = 1'b0;
      expected_colour  = prev_button_q ? next_colour(cur_colour_q) : cur_colour_q;

      pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;

      unique case (state_q)
         ST_SYNC: begin
            if (is_legal(colour)) begin
               cur_colour_d  = colour;
               prev_button_d = button;
               state_d       = ST_TRACK;
            end
         end
         ST_TRACK: begin
            // expected_colour is always legal, so 000/111 always land here as a mismatch.
            if (colour == expected_colour) begin
               wrap          = (cur_colour_q == COL_LAST) && (colour == COL_FIRST);
               cur_colour_d  = colour;
               prev_button_d = button;
            end else begin
               mismatch = 1'b1;
               state_d  = ST_FAULT;
            end
         end
         ST_FAULT: begin
            state_d = ST_SYNC;
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase

      // A clear on the same edge as a wrap discards the wrap.
      if (clear) begin
         loop_count_d = '0;
      end else if (wrap) begin
         loop_count_d = sat_inc(loop_count_q);
      end

      // A mismatch beats a simultaneous clear: the flag stays set and the
      // count restarts at one rather than zero.
      if (mismatch) begin
         err_d            = 1'b1;
         mismatch_count_d = clear ? CNT_W'(1) : sat_inc(mismatch_count_q);
      end else if (clear) begin
         err_d            = 1'b0;
         mismatch_count_d = '0;
      end

      err_pulse_d = mismatch;
      locked_d    = (state_d == ST_TRACK);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_SYNC;
         cur_colour_q     <= COL_FIRST;
         prev_button_q    <= 1'b0;
         pwm_cnt_q        <= '0;
         locked_q         <= 1'b0;
         err_q            <= 1'b0;
         err_pulse_q      <= 1'b0;
         loop_count_q     <= '0;
         mismatch_count_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge _d values,
         // independent of statement order.
         state_q          <= state_d;
         cur_colour_q     <= cur_colour_d;
         prev_button_q    <= prev_button_d;
         pwm_cnt_q        <= pwm_cnt_d;
         locked_q         <= locked_d;
         err_q            <= err_d;
         err_pulse_q      <= err_pulse_d;
         loop_count_q     <= loop_count_d;
         mismatch_count_q <= mismatch_count_d;
      end
   end

   // DUTY of zero never lights; DUTY at or above the period always lights.
   assign pwm_on = (32'(pwm_cnt_q) < DUTY);

   assign led_r = (state_q == ST_TRACK) & cur_colour_q[2] & pwm_on;
   assign led_g = (state_q == ST_TRACK) & cur_colour_q[1] & pwm_on;
   assign led_b = (state_q == ST_TRACK) & cur_colour_q[0] & pwm_on;

   assign locked         = locked_q;
   assign err            = err_q;
   assign err_pulse      = err_pulse_q;
   assign loop_count     = loop_count_q;
   assign mismatch_count = mismatch_count_q;

endmodule

// File: tb/tb_lights_checker.sv
// Bench for lights_checker: directed scenarios followed by random producer
// traffic, all checked against a spec-level reference model. Four instances
// share the inputs: default, CNT_W=2, DUTY=0 and DUTY=8.
module tb_lights_checker;

   localparam int PERIOD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] colour;
   logic       button;
   logic       clear;

   logic       m_locked, m_err, m_pulse, m_r, m_g, m_b;
   logic [7:0] m_loops, m_mism;
   logic       s_locked, s_err, s_pulse, s_r, s_g, s_b;
   logic [1:0] s_loops, s_mism;
   logic       z_locked, z_err, z_pulse, z_r, z_g, z_b;
   logic [7:0] z_loops, z_mism;
   logic       f_locked, f_err, f_pulse, f_r, f_g, f_b;
   logic [7:0] f_loops, f_mism;

   lights_checker #(.CNT_W(8), .PWM_PERIOD(PERIOD), .DUTY(4)) dut_main (
      .clk(clk), .rst(rst), .colour(colour), .button(button), .clear(clear),
      .locked(m_locked), .err(m_err), .err_pulse(m_pulse),
      .loop_count(m_loops), .mismatch_count(m_mism),
      .led_r(m_r), .led_g(m_g), .led_b(m_b));

   lights_checker #(.CNT_W(2), .PWM_PERIOD(PERIOD), .DUTY(4)) dut_sat (
      .clk(clk), .rst(rst), .colour(colour), .button(button), .clear(clear),
      .locked(s_locked), .err(s_err), .err_pulse(s_pulse),
      .loop_count(s_loops), .mismatch_count(s_mism),
      .led_r(s_r), .led_g(s_g), .led_b(s_b));

   lights_checker #(.CNT_W(8), .PWM_PERIOD(PERIOD), .DUTY(0)) dut_d0 (
      .clk(clk), .rst(rst), .colour(colour), .button(button), .clear(clear),
      .locked(z_locked), .err(z_err), .err_pulse(z_pulse),
      .loop_count(z_loops), .mismatch_count(z_mism),
      .led_r(z_r), .led_g(z_g), .led_b(z_b));

   lights_checker #(.CNT_W(8), .PWM_PERIOD(PERIOD), .DUTY(8)) dut_d8 (
      .clk(clk), .rst(rst), .colour(colour), .button(button), .clear(clear),
      .locked(f_locked), .err(f_err), .err_pulse(f_pulse),
      .loop_count(f_loops), .mismatch_count(f_mism),
      .led_r(f_r), .led_g(f_g), .led_b(f_b));

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: the checker's behaviour described in terms of the
   // producer's colour cycle, with unbounded counts saturated on comparison.
   typedef enum {M_HUNT, M_FOLLOW, M_RECOVER} mode_t;
   mode_t m_mode;
   int    m_cur;
   bit    m_pb;
   int    m_loop_n;
   int    m_mism_n;
   bit    m_err_f;
   bit    m_pulse_f;
   int    m_phase;

   logic [2:0] p;   // producer's current colour

   function automatic int nxt(input int c);
      return (c == 0 || c >= 6) ? 1 : c + 1;
   endfunction

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   function automatic logic [2:0] exp_leds(input int duty);
      return (m_mode == M_FOLLOW && m_phase < duty) ? 3'(m_cur) : 3'b000;
   endfunction

   task automatic model_reset();
      m_mode = M_HUNT; m_cur = 1; m_pb = 0;
      m_loop_n = 0; m_mism_n = 0; m_err_f = 0; m_pulse_f = 0; m_phase = 0;
   endtask

   task automatic model_edge(input int c, input bit b, input bit cl);
      bit bad  = 0;
      bit wrp  = 0;
      int want;
      m_phase = (m_phase + 1) % PERIOD;
      case (m_mode)
         M_HUNT: if (c >= 1 && c <= 6) begin
            m_cur = c; m_pb = b; m_mode = M_FOLLOW;
         end
         M_FOLLOW: begin
            want = m_pb ? nxt(m_cur) : m_cur;
            if (c == want) begin
               wrp = (m_cur == 6 && c == 1);
               m_cur = c; m_pb = b;
            end else begin
               bad = 1; m_mode = M_RECOVER;
            end
         end
         default: m_mode = M_HUNT;
      endcase
      if (wrp) m_loop_n++;
      if (cl) m_loop_n = 0;
      if (bad) begin
         m_err_f = 1;
         m_mism_n = cl ? 1 : m_mism_n + 1;
      end else if (cl) begin
         m_err_f = 0;
         m_mism_n = 0;
      end
      m_pulse_f = bad;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("locked",      32'(m_locked), 32'(m_mode == M_FOLLOW));
      chk("err",         32'(m_err),    32'(m_err_f));
      chk("err_pulse",   32'(m_pulse),  32'(m_pulse_f));
      chk("loop_count",  32'(m_loops),  32'(sat(m_loop_n, 255)));
      chk("mism_count",  32'(m_mism),   32'(sat(m_mism_n, 255)));
      chk("leds",        32'({m_r, m_g, m_b}), 32'(exp_leds(4)));
      chk("sat_loops",   32'(s_loops),  32'(sat(m_loop_n, 3)));
      chk("sat_mism",    32'(s_mism),   32'(sat(m_mism_n, 3)));
      chk("leds_duty0",  32'({z_r, z_g, z_b}), 32'(exp_leds(0)));
      chk("leds_duty8",  32'({f_r, f_g, f_b}), 32'(exp_leds(8)));
   endtask

   // One cycle: drive at the falling edge, check 1 time unit after the rise.
   task automatic step(input logic [2:0] c, input bit b, input bit cl);
      colour = c; button = b; clear = cl;
      @(posedge clk);
      model_edge(int'(c), b, cl);
      #1;
      check_all();
      @(negedge clk);
   endtask

   // Faithful producer: shows p, advances on its own edge when button is high.
   task automatic prod(input bit b, input bit cl);
      step(p, b, cl);
      if (b) p = 3'(nxt(int'(p)));
   endtask

   initial begin
      rst = 1'b1; colour = 3'b001; button = 1'b0; clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;
      p = 3'b001;

      // Reset and lock, then watch led_b follow the 4/8 duty.
      prod(0, 0);
      chk("lock_after_one_edge", 32'(m_locked), 32'd1);
      repeat (15) prod(0, 0);

      // Full sequence with button held: two wraps.
      repeat (13) prod(1, 0);
      chk("full_loops", 32'(m_loops), 32'd2);
      chk("full_mism",  32'(m_mism),  32'd0);

      // Step to 011, then hold with button low.
      prod(1, 0);
      repeat (10) prod(0, 0);
      chk("hold_err", 32'(m_err), 32'd0);

      // Unrequested advance to 100.
      step(3'b100, 0, 0);
      p = 3'b100;
      chk("hold_pulse",  32'(m_pulse),  32'd1);
      chk("hold_mism",   32'(m_mism),   32'd1);
      chk("hold_unlock", 32'(m_locked), 32'd0);
      prod(0, 0);
      chk("fault_pulse_gone", 32'(m_pulse),  32'd0);
      chk("fault_unlocked",   32'(m_locked), 32'd0);
      prod(0, 0);
      chk("relock", 32'(m_locked), 32'd1);
      repeat (3) prod(0, 0);

      // Illegal value while tracking, then held illegal.
      step(3'b111, 0, 0);
      chk("illegal_pulse", 32'(m_pulse), 32'd1);
      repeat (4) begin
         step(3'b111, 0, 0);
         chk("illegal_stays_sync", 32'(m_locked), 32'd0);
      end
      step(3'b010, 0, 0);
      p = 3'b010;
      chk("illegal_relock", 32'(m_locked), 32'd1);
      repeat (3) prod(0, 0);

      // Clear on the same edge as a mismatch, then clear alone while locked.
      step(3'b101, 0, 1);
      p = 3'b101;
      chk("collide_err",  32'(m_err),  32'd1);
      chk("collide_mism", 32'(m_mism), 32'd1);
      repeat (3) prod(0, 0);
      prod(0, 1);
      chk("clear_err",    32'(m_err),    32'd0);
      chk("clear_mism",   32'(m_mism),   32'd0);
      chk("clear_loops",  32'(m_loops),  32'd0);
      chk("clear_locked", 32'(m_locked), 32'd1);

      // Five loops: narrow counter saturates at 3.
      repeat (31) prod(1, 0);
      chk("sat_loops_3", 32'(s_loops), 32'd3);
      chk("wide_loops_5", 32'(m_loops), 32'd5);

      // Asynchronous reset between clock edges.
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;
      p = 3'b001;

      // Random producer traffic with occasional glitches and clears.
      repeat (1500) begin
         bit b;
         bit cl;
         b  = 1'($urandom_range(0, 1));
         cl = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 24) == 0) begin
            step(3'($urandom_range(0, 7)), b, cl);
            if (b) p = 3'(nxt(int'(p)));
         end else begin
            prod(b, cl);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
